// File: rtl/line_feeder.sv
// line_feeder: streams a frame from memory to a line filter, paced by filter interrupts; zero-line padding with LINE_FEEDER_PAD_EN.
// Latency: first pixel valid 2 cycles after the start is accepted, then one pixel per cycle while i_data_ready is high.
// Backpressure: i_data_ready low holds o_data; reads stop once the 2-entry prefetch buffer is fully committed.

// line_feeder_fifo: small ring buffer, power-of-two DEPTH, occupancy exported.
// Latency: pushed word visible at headData the cycle after the push.
// Backpressure: none internal; the caller never pushes when full or pops when empty.
module line_feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];
endmodule

module line_feeder #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
  input  logic              i_intr
);
  localparam int PRIME_PIX = PRIME_LINES * IMG_WIDTH;
  localparam int CNT_W     = $clog2(PRIME_PIX + 1);
  localparam int LINE_W    = $clog2(IMG_HEIGHT + 1);

  if (IMG_HEIGHT < PRIME_LINES || PRIME_LINES < 1 || IMG_WIDTH < 1 || PAD_LINES < 0) begin : gBadCfg
    $error("line_feeder: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, PRIME, WAIT_INTR, LINE, PAD_WAIT, PAD, FLUSH} stateT;

`ifdef LINE_FEEDER_PAD_EN
  localparam int    PAD_W       = $clog2(PAD_LINES + 2);
  localparam stateT AFTER_IMAGE = (PAD_LINES > 0) ? PAD_WAIT : FLUSH;
`else
  localparam stateT AFTER_IMAGE = FLUSH;
`endif

  stateT             state;
  logic [1:0]        credits;
  logic              intrQ;
  logic              rdPend;
  logic [CNT_W-1:0]  issuedCnt;
  logic [CNT_W-1:0]  sentCnt;
  logic [LINE_W-1:0] lineCnt;
`ifdef LINE_FEEDER_PAD_EN
  logic [PAD_W-1:0]  padCnt;
`endif

  logic [1:0]        fifoCount;
  logic [7:0]        fifoHead;
  logic              streaming;
  logic              bufValid;
  logic              pop;
  logic              xfer;
  logic              issue;
  logic              segLast;
  logic              intrRise;
  logic              creditTake;
  logic [CNT_W-1:0]  segLen;
  logic [2:0]        inUse;

  line_feeder_fifo #(.WIDTH(8), .DEPTH(2)) uBuf (
    .clk      (axi_clk),
    .rstN     (axi_reset_n),
    .push     (rdPend),
    .pushData (i_rd_data),
    .pop      (pop),
    .headData (fifoHead),
    .count    (fifoCount)
  );

  assign streaming = (state == PRIME) || (state == LINE);
  assign bufValid  = (fifoCount != 2'd0);
  assign pop       = bufValid && i_data_ready;
  assign segLen    = (state == PRIME) ? CNT_W'(PRIME_PIX) : CNT_W'(IMG_WIDTH);
  assign inUse     = {1'b0, fifoCount} + {2'b00, rdPend};

  // A slot freed by this cycle's pop may be refilled at once, which keeps one pixel per cycle flowing.
  assign issue   = streaming && (issuedCnt < segLen) &&
                   ((inUse < 3'd2) || ((inUse == 3'd2) && pop));
  assign o_rd_en = issue;

`ifdef LINE_FEEDER_PAD_EN
  assign o_data_valid = bufValid || (state == PAD);
  assign creditTake   = ((state == WAIT_INTR) || (state == PAD_WAIT)) && (credits != 2'd0);
`else
  assign o_data_valid = bufValid;
  assign creditTake   = (state == WAIT_INTR) && (credits != 2'd0);
`endif

  // Pad pixels never touch the buffer, so the masked head reads as zero there.
  assign o_data   = bufValid ? fifoHead : 8'd0;
  assign xfer     = o_data_valid && i_data_ready;
  assign segLast  = xfer && (sentCnt == segLen - 1'b1);
  assign intrRise = i_intr && !intrQ;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      intrQ   <= 1'b0;
      credits <= 2'd0;
    end else begin
      intrQ <= i_intr;
      if (state == IDLE)
        credits <= 2'd0;
      else if (intrRise && !creditTake && credits != 2'd3)
        credits <= credits + 1'b1;
      else if (creditTake && !intrRise)
        credits <= credits - 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state     <= IDLE;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rd_addr <= '0;
      rdPend    <= 1'b0;
      issuedCnt <= '0;
      sentCnt   <= '0;
      lineCnt   <= '0;
`ifdef LINE_FEEDER_PAD_EN
      padCnt    <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      rdPend <= issue;
      if (issue) begin
        o_rd_addr <= o_rd_addr + 1'b1;
        issuedCnt <= issuedCnt + 1'b1;
      end
      if (xfer) sentCnt <= sentCnt + 1'b1;

      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= PRIME;
            o_busy    <= 1'b1;
            o_rd_addr <= '0;
            issuedCnt <= '0;
            sentCnt   <= '0;
            lineCnt   <= LINE_W'(PRIME_LINES);
`ifdef LINE_FEEDER_PAD_EN
            padCnt    <= '0;
`endif
          end
        end
        PRIME: begin
          if (segLast) begin
            issuedCnt <= '0;
            sentCnt   <= '0;
            state     <= (PRIME_LINES == IMG_HEIGHT) ? AFTER_IMAGE : WAIT_INTR;
          end
        end
        WAIT_INTR: begin
          if (creditTake) state <= LINE;
        end
        LINE: begin
          if (segLast) begin
            issuedCnt <= '0;
            sentCnt   <= '0;
            lineCnt   <= lineCnt + 1'b1;
            state     <= (lineCnt == LINE_W'(IMG_HEIGHT - 1)) ? AFTER_IMAGE : WAIT_INTR;
          end
        end
`ifdef LINE_FEEDER_PAD_EN
        PAD_WAIT: begin
          if (creditTake) state <= PAD;
        end
        PAD: begin
          if (segLast) begin
            sentCnt <= '0;
            padCnt  <= padCnt + 1'b1;
            state   <= (padCnt == PAD_W'(PAD_LINES - 1)) ? FLUSH : PAD_WAIT;
          end
        end
`endif
        FLUSH: begin
          if (!bufValid && !rdPend) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
